// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: frame geometry, sample type and the
// fill state of a ping-pong frame bank.
package fft_pkg;

    localparam int SAMPLE_SIZE  = 16;
    localparam int BUFFER_SIZE  = 8;
    localparam int TWIDDLE_SIZE = 16;

    typedef logic signed [SAMPLE_SIZE-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // Slot index width; a one-slot frame still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One half of the ping-pong frame store: BUFFER_SIZE sample slots plus the
// EMPTY/FILLING/FULL state that arbitrates writer and reader ownership.
module fft_frame_bank #(
    parameter int SAMPLE_SIZE = fft_pkg::SAMPLE_SIZE,
    parameter int BUFFER_SIZE = fft_pkg::BUFFER_SIZE,
    parameter int IDX_W       = fft_pkg::idx_width(BUFFER_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_wr_en,
    input  logic [IDX_W-1:0]                     i_wr_idx,
    input  logic signed [SAMPLE_SIZE-1:0]        i_wr_data,
    input  logic                                 i_wr_last,
    input  logic                                 i_release,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]   o_frame,
    output fft_pkg::bank_state_e                 o_state
);
    import fft_pkg::*;

    bank_state_e                   r_state;
    logic signed [SAMPLE_SIZE-1:0] r_slot [BUFFER_SIZE];

    // Writer and reader never own the same bank at once, so release and
    // write strobes are mutually exclusive in practice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else if (i_release) begin
            r_state <= EMPTY;
        end else if (i_wr_en) begin
            r_state <= i_wr_last ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_slot[i_wr_idx] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < BUFFER_SIZE; k++) begin : g_pack
        assign o_frame[k*SAMPLE_SIZE +: SAMPLE_SIZE] = r_slot[k];
    end

    assign o_state = r_state;

endmodule

// File: rtl/fft_frame_assembler.sv
// Serial-to-parallel frame assembler feeding FFT_Top: two ping-pong banks,
// one filling from the sample stream while the other is offered as a frame.
module fft_frame_assembler #(
    parameter int SAMPLE_SIZE = fft_pkg::SAMPLE_SIZE,
    parameter int BUFFER_SIZE = fft_pkg::BUFFER_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic signed [SAMPLE_SIZE-1:0]        sample_in,
    input  logic                                 sample_valid,
    output logic                                 sample_ready,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]   frame_out,
    output logic                                 frame_valid,
    input  logic                                 frame_ready,
    output logic                                 overrun,
    output logic                                 overrun_seen
);
    import fft_pkg::*;

    localparam int IDX_W   = idx_width(BUFFER_SIZE);
    localparam int FRAME_W = BUFFER_SIZE * SAMPLE_SIZE;

    logic [IDX_W-1:0]   r_wr_idx;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               r_overrun;
    logic               r_overrun_seen;

    bank_state_e        w_state [2];
    logic [FRAME_W-1:0] w_frame [2];
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_frame_valid;
    logic               w_handshake;

    // Only a FULL write bank blocks input, which happens once both banks hold
    // frames and the write pointer has wrapped onto the read bank.
    assign w_ready       = rst_n & (w_state[r_wr_bank] != FULL);
    assign w_accept      = sample_valid & w_ready;
    assign w_last        = (r_wr_idx == IDX_W'(BUFFER_SIZE - 1));
    assign w_frame_valid = (w_state[r_rd_bank] == FULL);
    assign w_handshake   = w_frame_valid & frame_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .SAMPLE_SIZE (SAMPLE_SIZE),
            .BUFFER_SIZE (BUFFER_SIZE),
            .IDX_W       (IDX_W)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_accept & (r_wr_bank == 1'(b))),
            .i_wr_idx  (r_wr_idx),
            .i_wr_data (sample_in),
            .i_wr_last (w_last),
            .i_release (w_handshake & (r_rd_bank == 1'(b))),
            .o_frame   (w_frame[b]),
            .o_state   (w_state[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_idx <= w_last ? '0 : r_wr_idx + IDX_W'(1);
                if (w_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_handshake) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun      <= 1'b0;
            r_overrun_seen <= 1'b0;
        end else begin
            r_overrun <= sample_valid & ~w_ready;
            if (sample_valid & ~w_ready) begin
                r_overrun_seen <= 1'b1;
            end
        end
    end

    // Zeroing the idle bus makes reset visibly clear frame_out without
    // resetting the sample storage itself.
    assign frame_out    = w_frame_valid ? w_frame[r_rd_bank] : '0;
    assign frame_valid  = w_frame_valid;
    assign sample_ready = w_ready;
    assign overrun      = r_overrun;
    assign overrun_seen = r_overrun_seen;

endmodule

// File: tb/tb_fft_frame_assembler.sv
// Scoreboard bench for fft_frame_assembler: a two-deep frame queue model
// predicts ready/valid/overrun each cycle and the frame on every handshake.
module tb_fft_frame_assembler;

    localparam int SS = 16;
    localparam int BS = 8;
    localparam int FW = SS * BS;

    logic                 clk;
    logic                 rst_n;
    logic signed [SS-1:0] sample_in;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [FW-1:0]        frame_out;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 overrun;
    logic                 overrun_seen;

    fft_frame_assembler #(.SAMPLE_SIZE(SS), .BUFFER_SIZE(BS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overrun      (overrun),
        .overrun_seen (overrun_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_fv = 0;

    logic [FW-1:0] sb_q [$];
    logic [FW-1:0] part;
    int            pidx;
    logic          exp_ovr;
    logic          exp_seen;

    typedef struct {
        logic [SS-1:0] val;
        logic [SS-1:0] exp_bits;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] seq_frame(input int first);
        logic [FW-1:0] f;
        for (int k = 0; k < BS; k++) f[k*SS +: SS] = SS'(first + k);
        return f;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        part     = '0;
        pidx     = 0;
        exp_ovr  = 1'b0;
        exp_seen = 1'b0;
    endtask

    // Called at posedge+1: drive, check pre-edge outputs, advance the model.
    task automatic cyc(input logic v, input logic [SS-1:0] d, input logic fr);
        logic          rdy_e;
        logic [FW-1:0] tmp;
        sample_valid = v;
        sample_in    = d;
        frame_ready  = fr;
        #1;
        rdy_e = (sb_q.size() < 2);
        chk("sample_ready", FW'(sample_ready), FW'(rdy_e));
        chk("frame_valid", FW'(frame_valid), FW'(sb_q.size() > 0));
        chk("overrun", FW'(overrun), FW'(exp_ovr));
        chk("overrun_seen", FW'(overrun_seen), FW'(exp_seen));
        if (frame_valid) cnt_fv++;
        if (sb_q.size() > 0) chk("frame_out", frame_out, sb_q[0]);
        @(posedge clk);
        if (fr && sb_q.size() > 0) tmp = sb_q.pop_front();
        exp_ovr = v && !rdy_e;
        if (exp_ovr) exp_seen = 1'b1;
        if (v && rdy_e) begin
            part[pidx*SS +: SS] = d;
            if (pidx == BS - 1) begin
                sb_q.push_back(part);
                pidx = 0;
            end else begin
                pidx++;
            end
        end
        #1;
    endtask

    initial begin
        tbl[0] = '{16'hFFFF, 16'hFFFF};
        tbl[1] = '{16'h8000, 16'h8000};
        tbl[2] = '{16'h7FFF, 16'h7FFF};
        tbl[3] = '{16'h0000, 16'h0000};
        tbl[4] = '{SS'(-1),     16'hFFFF};
        tbl[5] = '{SS'(-32768), 16'h8000};
        tbl[6] = '{SS'(32767),  16'h7FFF};
        tbl[7] = '{SS'(0),      16'h0000};

        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        frame_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame_valid", FW'(frame_valid), '0);
        chk("rst_frame_out", frame_out, '0);
        chk("rst_overrun", FW'(overrun), '0);
        chk("rst_overrun_seen", FW'(overrun_seen), '0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", FW'(sample_ready), FW'(1'b1));

        // Test 1: one frame 1..8, visible the cycle after the last sample
        for (int i = 1; i <= 8; i++) cyc(1'b1, SS'(i), 1'b0);
        chk("t1_valid", FW'(frame_valid), FW'(1'b1));
        chk("t1_frame", frame_out, seq_frame(1));

        // Test 2: stall the consumer, fill second bank, then overrun
        for (int i = 9; i <= 24; i++) cyc(1'b1, SS'(i), 1'b0);
        chk("t2_held_frame", frame_out, seq_frame(1));
        chk("t2_ready_low", FW'(sample_ready), '0);
        chk("t2_overrun_seen", FW'(overrun_seen), FW'(1'b1));

        // Test 3: single frame_ready pulse switches straight to 9..16
        cyc(1'b0, '0, 1'b1);
        chk("t3_valid", FW'(frame_valid), FW'(1'b1));
        chk("t3_frame", frame_out, seq_frame(9));
        chk("t3_ready", FW'(sample_ready), FW'(1'b1));
        cyc(1'b0, '0, 1'b1);
        chk("t3_drained", FW'(frame_valid), '0);

        // Test 4: signed extremes stored bit-exact
        for (int i = 0; i < 8; i++) cyc(1'b1, tbl[i].val, 1'b0);
        for (int i = 0; i < 8; i++) chk("t4_slot", FW'(frame_out[i*SS +: SS]), FW'(tbl[i].exp_bits));
        cyc(1'b0, '0, 1'b1);

        // Test 5: async reset with a pending frame and a partial frame
        for (int i = 0; i < 8; i++) cyc(1'b1, SS'(100 + i), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, SS'(200 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", FW'(frame_valid), '0);
        chk("t5_async_frame", frame_out, '0);
        chk("t5_async_seen", FW'(overrun_seen), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1'b1, SS'(300 + i), 1'b0);
        chk("t5_clean_frame", frame_out, seq_frame(300));
        cyc(1'b0, '0, 1'b1);

        // Test 6: streaming with an always-ready consumer
        cnt_fv = 0;
        for (int i = 0; i < 64; i++) cyc(1'b1, SS'(400 + i), 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("t6_frame_count", FW'(cnt_fv), FW'(8));
        chk("t6_no_overrun", FW'(overrun_seen), '0);
        chk("t6_sb_empty", FW'(sb_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
